gcd_host_loader: RTL and testbench

Host-side driver for the KGP-RISC GCD program. It holds the processor in reset, writes operands a and b into data-memory words 0 and 4, then releases the processor. It snoops the processor's store path for the result write to word 8, latches the GCD, and reports done, or reports timeout if no result arrives. It sits between a host/test controller and the KGPRISC data-memory write port, and owns the processor's reset.

---
 rtl/gcd_host_loader.sv | 148 ++++++++++++++
 tb/tb_gcd_host_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gcd_host_loader.sv
// Host loader for the KGP-RISC GCD program: writes operands, runs the core, snoops the result store.
// Define GCD_HOST_CHECK_EN to compile in the subtractive golden checker that drives mismatch.
module gcd_host_loader #(
  parameter logic [31:0] A_ADDR         = 32'd0,
  parameter logic [31:0] B_ADDR         = 32'd4,
  parameter logic [31:0] RESULT_ADDR    = 32'd8,
  parameter int unsigned TIMEOUT_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] gcd_out,
  output logic        mismatch,
  output logic        cpu_rst,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata
);

  // state   | meaning
  // IDLE    | waiting for start, processor held in reset
  // LOAD_A  | writing operand a to data memory
  // LOAD_B  | writing operand b to data memory
  // RUN     | processor released, snooping for the result store
  // DONE    | result latched
  // TIMEOUT | no result within TIMEOUT_CYCLES
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, DONE, TIMEOUT} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [31:0]   b_q;
  logic [CW-1:0] cnt;
  logic          result_hit;
  logic          accept;

  assign result_hit = cpu_mem_we && (cpu_mem_addr == RESULT_ADDR);
  assign accept     = start && (state == IDLE || state == DONE || state == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      b_q       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      gcd_out   <= '0;
      cpu_rst   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            state     <= LOAD_A;
            b_q       <= b_in;
            cnt       <= '0;
            gcd_out   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= A_ADDR;
            mem_wdata <= a_in;
          end
        end
        LOAD_A: begin
          state     <= LOAD_B;
          mem_addr  <= B_ADDR;
          mem_wdata <= b_q;
        end
        LOAD_B: begin
          state     <= RUN;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          cpu_rst   <= 1'b0;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          // a result store on the final count still wins over the timeout
          if (result_hit) begin
            state   <= DONE;
            gcd_out <= cpu_mem_wdata;
            busy    <= 1'b0;
            done    <= 1'b1;
            cpu_rst <= 1'b1;
          end else if (cnt == LAST) begin
            state   <= TIMEOUT;
            busy    <= 1'b0;
            timeout <= 1'b1;
            cpu_rst <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_HOST_CHECK_EN
  logic [31:0] ga, gb, golden;
  logic        resolved, pend;

  assign resolved = (ga == 32'd0) || (gb == 32'd0) || (ga == gb);
  assign golden   = (ga == 32'd0) ? gb : ga;

  always_ff @(posedge clk) begin
    if (rst) begin
      ga       <= '0;
      gb       <= '0;
      pend     <= 1'b0;
      mismatch <= 1'b0;
    end else if (accept) begin
      ga       <= a_in;
      gb       <= b_in;
      pend     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (!resolved) begin
        if (ga > gb) ga <= ga - gb;
        else         gb <= gb - ga;
      end
      // a result that beats the reference is compared once the reference settles
      if (state == RUN && result_hit) begin
        if (resolved) mismatch <= (cpu_mem_wdata != golden);
        else          pend     <= 1'b1;
      end else if (pend && resolved) begin
        mismatch <= (gcd_out != golden);
        pend     <= 1'b0;
      end
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_host_loader.sv
// Directed plus randomized bench for gcd_host_loader; the processor is a stub driven from here.
module tb_gcd_host_loader;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a_in, b_in;
  logic        busy, done, timeout, mismatch, cpu_rst, mem_we;
  logic [31:0] gcd_out, mem_addr, mem_wdata;
  logic        cpu_mem_we;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gcd_host_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .timeout(timeout), .gcd_out(gcd_out),
    .mismatch(mismatch), .cpu_rst(cpu_rst), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_mem_we(cpu_mem_we),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Euclid by remainder; independent of the subtractive hardware reference
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // one full transaction; the stub stores 'stored' to the result address after d RUN cycles
  task automatic run_gcd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] stored,
                         input int d, input bit pulse);
    logic [31:0] g;
    g = ref_gcd(a, b);
    a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    chk("load_a_we", mem_we, 1);
    chk("load_a_addr", mem_addr, 0);
    chk("load_a_data", mem_wdata, a);
    chk("load_a_cpu_rst", cpu_rst, 1);
    chk("load_a_busy", busy, 1);
    chk("start_clears_done", done, 0);
    tick();
    chk("load_b_we", mem_we, 1);
    chk("load_b_addr", mem_addr, 4);
    chk("load_b_data", mem_wdata, b);
    chk("load_b_cpu_rst", cpu_rst, 1);
    tick();
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_we", mem_we, 0);
    chk("run_addr", mem_addr, 0);
    chk("run_data", mem_wdata, 0);
    chk("run_busy", busy, 1);
    for (int i = 0; i < d; i++) begin
      start = pulse && (i == 0);
      cpu_mem_we = (i == 1); cpu_mem_addr = 32'd12; cpu_mem_wdata = 32'hdead;
      tick();
      chk("run_no_done", done, 0);
      chk("run_no_timeout", timeout, 0);
      chk("run_no_reload", mem_we, 0);
    end
    start = 1'b0;
    cpu_mem_we = 1'b1; cpu_mem_addr = 32'd8; cpu_mem_wdata = stored;
    tick();
    cpu_mem_we = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0;
    chk("done", done, 1);
    chk("done_not_timeout", timeout, 0);
    chk("gcd_out", gcd_out, stored);
    chk("done_cpu_rst", cpu_rst, 1);
    chk("done_busy", busy, 0);
    if (stored == g) chk("gcd_vs_model", gcd_out, g);
`ifdef GCD_HOST_CHECK_EN
    repeat (300) tick();
    chk("mismatch", mismatch, (stored != g));
`else
    chk("mismatch", mismatch, 0);
`endif
  endtask

  initial begin
    int cycles;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    cpu_mem_we = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_gcd_out", gcd_out, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    run_gcd(32'd12, 32'd18, 32'd6, 5, 1'b0);
    run_gcd(32'd0, 32'd7, 32'd7, 3, 1'b0);
    run_gcd(32'd9, 32'd0, 32'd9, 2, 1'b0);
    run_gcd(32'd5, 32'd5, 32'd5, 4, 1'b0);
    run_gcd(32'd40, 32'd24, 32'd8, T - 1, 1'b0);
    run_gcd(32'd100, 32'd75, 32'd25, 6, 1'b1);
    run_gcd(32'd21, 32'd14, 32'd3, 3, 1'b0);

    // timeout: only a stray store to a non-result address
    a_in = 32'd30; b_in = 32'd45; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("to_cpu_rst_low", cpu_rst, 0);
    cpu_mem_we = 1'b1; cpu_mem_addr = 32'd12; cpu_mem_wdata = 32'd15;
    cycles = 0;
    while (timeout !== 1'b1 && cycles < 40) begin
      tick();
      cpu_mem_we = 1'b0;
      cycles++;
    end
    chk("timeout_latency", cycles, T);
    chk("timeout_flag", timeout, 1);
    chk("timeout_done", done, 0);
    chk("timeout_gcd_out", gcd_out, 0);
    chk("timeout_cpu_rst", cpu_rst, 1);
    chk("timeout_busy", busy, 0);
    tick();
    chk("timeout_held", timeout, 1);

    // reset while running
    a_in = 32'd8; b_in = 32'd12; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre_rst_cpu_rst", cpu_rst, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run_busy", busy, 0);
    chk("rst_run_cpu_rst", cpu_rst, 1);
    chk("rst_run_gcd_out", gcd_out, 0);
    chk("rst_run_timeout", timeout, 0);
    cpu_mem_we = 1'b1; cpu_mem_addr = 32'd8; cpu_mem_wdata = 32'd4;
    tick();
    cpu_mem_we = 1'b0;
    chk("idle_store_ignored", done, 0);
    chk("idle_cpu_rst", cpu_rst, 1);

    for (int k = 0; k < 8; k++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      run_gcd(ra, rb, ref_gcd(ra, rb), $urandom_range(0, T - 1), k[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
